// File: rtl/arp_packet_tx_pkg.sv
// Shared network constants and types for the ARP transmit and receive paths.
// The transmitter takes its Ethernet/ARP field values and frame length from here.
package arp_packet_tx_pkg;

    localparam logic [15:0] ARP_TYPE     = 16'h0806;
    localparam logic [15:0] IP_TYPE      = 16'h0800;
    localparam logic [15:0] HW_TYPE      = 16'h0001;
    localparam logic [15:0] REQ_OPCODE   = 16'h0001;
    localparam logic [15:0] REPLY_OPCODE = 16'h0002;
    localparam logic [7:0]  HLEN         = 8'd6;
    localparam logic [7:0]  PLEN         = 8'd4;

    localparam int          FRAME_WORDS  = 15;
    localparam logic [3:0]  LAST_WORD    = 4'(FRAME_WORDS - 1);
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } arp_tx_state_e;

    // Everything that differs between frames, captured once when a frame is loaded.
    typedef struct packed {
        logic [47:0] dstMac;
        logic [47:0] srcMac;
        logic [15:0] oper;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_fields_t;

endpackage

// File: rtl/arp_packet_tx_if.sv
// Word-wide MAC transmit stream: data with sop/eop/mod framing and a dval/rdy handshake.
interface arp_packet_tx_if;

    logic [31:0] Mac_tx_data;
    logic [1:0]  Mac_tx_mod;
    logic        Mac_tx_sop;
    logic        Mac_tx_eop;
    logic        Mac_tx_dval;
    logic        Mac_tx_rdy;

    modport master (
        output Mac_tx_data, Mac_tx_mod, Mac_tx_sop, Mac_tx_eop, Mac_tx_dval,
        input  Mac_tx_rdy
    );

    modport slave (
        input  Mac_tx_data, Mac_tx_mod, Mac_tx_sop, Mac_tx_eop, Mac_tx_dval,
        output Mac_tx_rdy
    );

endinterface

// File: rtl/arp_tx_word_mux.sv
// Combinational word selector: maps the word index and latched ARP fields to a 32-bit
// frame word, first byte in the top lane. Words 11..14 are the zero tail.
module arp_tx_word_mux
    import arp_packet_tx_pkg::*;
(
    input  arp_fields_t fields_i,
    input  logic [3:0]  wordIdx_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        case (wordIdx_i)
            4'd0:    word_o = fields_i.dstMac[47:16];
            4'd1:    word_o = {fields_i.dstMac[15:0], fields_i.srcMac[47:32]};
            4'd2:    word_o = fields_i.srcMac[31:0];
            4'd3:    word_o = {ARP_TYPE, HW_TYPE};
            4'd4:    word_o = {IP_TYPE, HLEN, PLEN};
            4'd5:    word_o = {fields_i.oper, fields_i.srcMac[47:32]};
            4'd6:    word_o = fields_i.srcMac[31:0];
            4'd7:    word_o = fields_i.spa;
            4'd8:    word_o = fields_i.tha[47:16];
            4'd9:    word_o = {fields_i.tha[15:0], fields_i.tpa[31:16]};
            4'd10:   word_o = {fields_i.tpa[15:0], 16'h0000};
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/arp_packet_tx.sv
// ARP request/reply frame generator: queues one pending request and one pending reply,
// latches the addresses for the chosen frame and streams it as 15 words to the MAC.
module arp_packet_tx
    import arp_packet_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] Local_MAC,
    input  logic [31:0] Local_IP,
    input  logic [31:0] ARPReqDstIP,
    input  logic [47:0] DstMacAddr,
    input  logic [31:0] DstIPAddr,
    input  logic        ARPReqSend,
    input  logic        ARPReplySend,
    arp_packet_tx_if.master macTx,
    output logic        Busy,
    output logic        ARPSendDone
);

    arp_tx_state_e state_q, state_d;
    logic [3:0]    wordCnt_q, wordCnt_d;
    logic          reqPend_q, reqPend_d;
    logic          replyPend_q, replyPend_d;
    arp_fields_t   fields_q, fields_d;
    logic          reqClr, replyClr;
    logic          accept;
    logic [31:0]   muxWord;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wordCnt_q   <= '0;
            reqPend_q   <= 1'b0;
            replyPend_q <= 1'b0;
            fields_q    <= '0;
        end else begin
            state_q     <= state_d;
            wordCnt_q   <= wordCnt_d;
            reqPend_q   <= reqPend_d;
            replyPend_q <= replyPend_d;
            fields_q    <= fields_d;
        end
    end

    assign accept = (state_q == SEND) && macTx.Mac_tx_rdy;

    always_comb begin
        state_d   = state_q;
        wordCnt_d = wordCnt_q;
        fields_d  = fields_q;
        reqClr    = 1'b0;
        replyClr  = 1'b0;
        case (state_q)
            IDLE: begin
                // A same-cycle pulse counts too, so LOAD follows the pulse directly.
                if (reqPend_q || replyPend_q || ARPReqSend || ARPReplySend)
                    state_d = LOAD;
            end
            LOAD: begin
                wordCnt_d       = '0;
                fields_d.srcMac = Local_MAC;
                fields_d.spa    = Local_IP;
                if (replyPend_q) begin
                    replyClr        = 1'b1;
                    fields_d.dstMac = DstMacAddr;
                    fields_d.oper   = REPLY_OPCODE;
                    fields_d.tha    = DstMacAddr;
                    fields_d.tpa    = DstIPAddr;
                end else begin
                    reqClr          = 1'b1;
                    fields_d.dstMac = BCAST_MAC;
                    fields_d.oper   = REQ_OPCODE;
                    fields_d.tha    = '0;
                    fields_d.tpa    = ARPReqDstIP;
                end
                state_d = SEND;
            end
            SEND: begin
                if (accept) begin
                    if (wordCnt_q == LAST_WORD)
                        state_d = DONE;
                    else
                        wordCnt_d = wordCnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A pulse arriving in the same cycle LOAD consumes its flag keeps the flag set.
    assign reqPend_d   = ARPReqSend   | (reqPend_q   & ~reqClr);
    assign replyPend_d = ARPReplySend | (replyPend_q & ~replyClr);

    arp_tx_word_mux u_wordMux (
        .fields_i  (fields_q),
        .wordIdx_i (wordCnt_q),
        .word_o    (muxWord)
    );

    assign macTx.Mac_tx_dval = (state_q == SEND);
    assign macTx.Mac_tx_data = (state_q == SEND) ? muxWord : '0;
    assign macTx.Mac_tx_sop  = (state_q == SEND) && (wordCnt_q == 4'd0);
    assign macTx.Mac_tx_eop  = (state_q == SEND) && (wordCnt_q == LAST_WORD);
    assign macTx.Mac_tx_mod  = 2'b00;
    assign Busy              = (state_q != IDLE);
    assign ARPSendDone       = (state_q == DONE);

endmodule

// File: tb/tb_arp_packet_tx.sv
// Bench for arp_packet_tx: a byte-level ARP frame model plus a cycle model of the
// pending/accept timing, compared against the MAC stream on every cycle.
module tb_arp_packet_tx;

    logic        clk;
    logic        rst_n;
    logic [47:0] localMac, peerMac;
    logic [31:0] localIp, reqIp, peerIp;
    logic        reqSend, replySend;
    logic        busy, sendDone;

    arp_packet_tx_if macIf ();

    arp_packet_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Local_MAC    (localMac),
        .Local_IP     (localIp),
        .ARPReqDstIP  (reqIp),
        .DstMacAddr   (peerMac),
        .DstIPAddr    (peerIp),
        .ARPReqSend   (reqSend),
        .ARPReplySend (replySend),
        .macTx        (macIf),
        .Busy         (busy),
        .ARPSendDone  (sendDone)
    );

    int numChecks = 0;
    int numFail   = 0;
    int cycleCnt  = 0;
    int rdyMode   = 0;
    int sopAcc    = 0;
    int eopAcc    = 0;

    bit           mActive  = 0;
    int           mPos     = 0;
    bit           pendReq  = 0;
    bit           pendRep  = 0;
    logic [479:0] mFrame   = '0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // 60-byte ARP frame laid out byte by byte, packed with byte 0 in the top bits.
    function automatic logic [479:0] buildFrame(input bit isReply, input logic [47:0] lmac,
                                                input logic [31:0] lip, input logic [47:0] pmac,
                                                input logic [31:0] pip, input logic [31:0] rip);
        logic [7:0]   b [60];
        logic [47:0]  dst, tha;
        logic [31:0]  tpa;
        logic [15:0]  oper;
        logic [479:0] f;
        dst  = isReply ? pmac : {48{1'b1}};
        tha  = isReply ? pmac : 48'h0;
        tpa  = isReply ? pip : rip;
        oper = isReply ? 16'd2 : 16'd1;
        for (int k = 0; k < 60; k++) b[k] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            b[k]      = dst[8*(5-k) +: 8];
            b[6 + k]  = lmac[8*(5-k) +: 8];
            b[22 + k] = lmac[8*(5-k) +: 8];
            b[32 + k] = tha[8*(5-k) +: 8];
        end
        b[12] = 8'h08; b[13] = 8'h06;
        b[14] = 8'h00; b[15] = 8'h01;
        b[16] = 8'h08; b[17] = 8'h00;
        b[18] = 8'h06; b[19] = 8'h04;
        b[20] = oper[15:8]; b[21] = oper[7:0];
        for (int k = 0; k < 4; k++) begin
            b[28 + k] = lip[8*(3-k) +: 8];
            b[38 + k] = tpa[8*(3-k) +: 8];
        end
        for (int k = 0; k < 60; k++) f[8*(59-k) +: 8] = b[k];
        return f;
    endfunction

    function automatic logic [31:0] wordOf(input logic [479:0] f, input int i);
        return f[32*(14-i) +: 32];
    endfunction

    // Advances the reference by one clock edge using the inputs present at that edge.
    task automatic modelStep();
        bit clrReq = 0;
        bit clrRep = 0;
        if (!rst_n) begin
            mActive = 0; mPos = 0; pendReq = 0; pendRep = 0;
            return;
        end
        if (!mActive) begin
            if (pendReq || pendRep || reqSend || replySend) begin
                mActive = 1;
                mPos    = -1;
            end
        end else if (mPos == -1) begin
            clrRep = pendRep;
            clrReq = !pendRep;
            mFrame = buildFrame(pendRep, localMac, localIp, peerMac, peerIp, reqIp);
            mPos   = 0;
        end else if (mPos < 15) begin
            if (macIf.Mac_tx_rdy) mPos++;
        end else begin
            mActive = 0;
        end
        pendReq = reqSend   | (pendReq & !clrReq);
        pendRep = replySend | (pendRep & !clrRep);
    endtask

    initial begin
        bit expDval;
        forever begin
            @(posedge clk);
            #1;
            modelStep();
            expDval = mActive && (mPos >= 0) && (mPos < 15);
            checkOutput("dval", 64'(macIf.Mac_tx_dval), 64'(expDval));
            checkOutput("sop", 64'(macIf.Mac_tx_sop), 64'(expDval && mPos == 0));
            checkOutput("eop", 64'(macIf.Mac_tx_eop), 64'(expDval && mPos == 14));
            checkOutput("mod", 64'(macIf.Mac_tx_mod), 64'd0);
            checkOutput("busy", 64'(busy), 64'(mActive));
            checkOutput("done", 64'(sendDone), 64'(mActive && mPos == 15));
            if (expDval)
                checkOutput($sformatf("word%0d", mPos), 64'(macIf.Mac_tx_data), 64'(wordOf(mFrame, mPos)));
            else
                checkOutput("dataIdle", 64'(macIf.Mac_tx_data), 64'd0);
        end
    end

    // Mid-cycle view: counts accepted sop/eop and checks a stalled word does not move.
    initial begin
        bit          prevStall = 0;
        logic [33:0] prevWord  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 0;
            end else begin
                if (prevStall)
                    checkOutput("stallHold", 64'({macIf.Mac_tx_sop, macIf.Mac_tx_eop, macIf.Mac_tx_data}),
                                64'(prevWord));
                if (macIf.Mac_tx_dval && macIf.Mac_tx_rdy && macIf.Mac_tx_sop) sopAcc++;
                if (macIf.Mac_tx_dval && macIf.Mac_tx_rdy && macIf.Mac_tx_eop) eopAcc++;
                prevStall = macIf.Mac_tx_dval && !macIf.Mac_tx_rdy;
                prevWord  = {macIf.Mac_tx_sop, macIf.Mac_tx_eop, macIf.Mac_tx_data};
            end
        end
    end

    initial begin
        macIf.Mac_tx_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdyMode)
                1:       macIf.Mac_tx_rdy = ~macIf.Mac_tx_rdy;
                2:       macIf.Mac_tx_rdy = ($urandom_range(0, 3) != 0);
                default: macIf.Mac_tx_rdy = 1'b1;
            endcase
        end
    end

    task automatic applyStimulus(input bit req, input bit rep, output int pulseCycle);
        @(posedge clk);
        #2;
        reqSend    = req;
        replySend  = rep;
        pulseCycle = cycleCnt;
        @(posedge clk);
        #2;
        reqSend   = 0;
        replySend = 0;
    endtask

    task automatic waitDone(input string name, output int doneCycle);
        doneCycle = -1;
        for (int i = 0; i < 200 && doneCycle < 0; i++) begin
            @(posedge clk);
            #1;
            if (sendDone) doneCycle = cycleCnt;
        end
        if (doneCycle < 0) checkOutput({name, "Timeout"}, 64'd0, 64'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Dval"}, 64'(macIf.Mac_tx_dval), 64'd0);
        checkOutput({tag, "Sop"},  64'(macIf.Mac_tx_sop),  64'd0);
        checkOutput({tag, "Eop"},  64'(macIf.Mac_tx_eop),  64'd0);
        checkOutput({tag, "Mod"},  64'(macIf.Mac_tx_mod),  64'd0);
        checkOutput({tag, "Data"}, 64'(macIf.Mac_tx_data), 64'd0);
        checkOutput({tag, "Busy"}, 64'(busy),              64'd0);
        checkOutput({tag, "Done"}, 64'(sendDone),          64'd0);
    endtask

    initial begin
        int n, c1, c2;
        bit found;
        logic [479:0] f;

        rst_n     = 0;
        reqSend   = 0;
        replySend = 0;
        localMac  = 48'h000A_3501_0203;
        localIp   = 32'hC0A8_0102;
        reqIp     = 32'hC0A8_0101;
        peerMac   = 48'h1122_3344_5566;
        peerIp    = 32'hC0A8_0105;

        #3;
        checkResetOutputs("reset");

        f = buildFrame(0, localMac, localIp, peerMac, peerIp, reqIp);
        checkOutput("pinReqW0",  64'(wordOf(f, 0)),  64'hFFFF_FFFF);
        checkOutput("pinReqW3",  64'(wordOf(f, 3)),  64'h0806_0001);
        checkOutput("pinReqW5",  64'(wordOf(f, 5)),  64'h0001_000A);
        checkOutput("pinReqW9",  64'(wordOf(f, 9)),  64'h0000_C0A8);
        checkOutput("pinReqW10", 64'(wordOf(f, 10)), 64'h0101_0000);
        f = buildFrame(1, localMac, localIp, peerMac, peerIp, reqIp);
        checkOutput("pinRepW0",  64'(wordOf(f, 0)),  64'h1122_3344);
        checkOutput("pinRepW1",  64'(wordOf(f, 1)),  64'h5566_000A);
        checkOutput("pinRepW5",  64'(wordOf(f, 5)),  64'h0002_000A);
        checkOutput("pinRepW8",  64'(wordOf(f, 8)),  64'h1122_3344);
        checkOutput("pinRepW10", 64'(wordOf(f, 10)), 64'h0105_0000);

        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1;

        applyStimulus(1, 0, n);
        waitDone("req", c1);
        checkOutput("reqLatency", 64'(c1 - n), 64'd17);

        applyStimulus(0, 1, n);
        waitDone("reply", c1);
        checkOutput("replyLatency", 64'(c1 - n), 64'd17);

        sopAcc  = 0;
        eopAcc  = 0;
        rdyMode = 1;
        applyStimulus(1, 0, n);
        waitDone("backpressure", c1);
        rdyMode = 0;
        checkOutput("bpSopCount", 64'(sopAcc), 64'd1);
        checkOutput("bpEopCount", 64'(eopAcc), 64'd1);

        applyStimulus(1, 1, n);
        waitDone("bothFirst", c1);
        waitDone("bothSecond", c2);
        checkOutput("bothFirstLatency", 64'(c1 - n), 64'd17);
        checkOutput("bothSecondLatency", 64'(c2 - n), 64'd35);

        applyStimulus(0, 1, n);
        @(posedge clk);
        #2;
        peerMac  = 48'hDEAD_BEEF_0001;
        peerIp   = 32'h0A00_0001;
        localMac = 48'h0200_0000_0042;
        waitDone("holdAddr", c1);
        checkOutput("holdAddrLatency", 64'(c1 - n), 64'd17);

        sopAcc = 0;
        eopAcc = 0;
        applyStimulus(1, 0, n);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #2;
            if (mActive && mPos == 7) found = 1;
        end
        if (!found) checkOutput("reachWord7Timeout", 64'd0, 64'd1);
        rst_n = 0;
        #1;
        checkResetOutputs("midReset");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1;
        repeat (25) @(posedge clk);
        #2;
        checkOutput("noEopAfterReset", 64'(eopAcc), 64'd0);
        checkOutput("noStrayFrame", 64'(sopAcc), 64'd1);
        applyStimulus(1, 0, n);
        waitDone("afterReset", c1);
        checkOutput("afterResetLatency", 64'(c1 - n), 64'd17);
        checkOutput("afterResetEop", 64'(eopAcc), 64'd1);

        rdyMode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            reqSend   = ($urandom_range(0, 15) == 0);
            replySend = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                localMac = {16'($urandom), $urandom};
                localIp  = $urandom;
                reqIp    = $urandom;
                peerMac  = {16'($urandom), $urandom};
                peerIp   = $urandom;
            end
        end
        @(posedge clk);
        #2;
        reqSend   = 0;
        replySend = 0;
        rdyMode   = 0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #2;
            if (!mActive && !pendReq && !pendRep) found = 1;
        end
        if (!found) checkOutput("drainTimeout", 64'd0, 64'd1);
        checkOutput("drainBusy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
        $finish;
    end

endmodule
